// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA display path.
// Samples HS/VS/RGB on the pixel clock, recovers pixel position from the sync edges,
// thresholds each active pixel to one bit and writes it into a WIDTH x HEIGHT bitmap store.
//
// Ports:
//   CLK          pixel clock
//   CPU_RESETN   synchronous reset, active high (despite the name)
//   VGA_HS/VS    sync inputs, active low
//   VGA_R/G/B    3-bit colour inputs
//   capture_en   level; 1 = capture frames continuously
//   pix_we       bitmap write strobe
//   pix_addr     row*WIDTH+col of the write, holds when pix_we=0
//   pix_data     thresholded pixel
//   frame_done   one-cycle pulse after the last pixel of a frame is written
//   busy         1 while waiting for VS or capturing a frame
//   sync_err     sticky line-length / frame-restart error
module vga_capture #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned HEIGHT = 9,
  parameter int unsigned HBP    = 144,
  parameter int unsigned VBP    = 31,
  parameter int unsigned HTOTAL = 800,
  parameter int unsigned THRESH = 11,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic              VGA_HS,
  input  logic              VGA_VS,
  input  logic [2:0]        VGA_R,
  input  logic [2:0]        VGA_G,
  input  logic [2:0]        VGA_B,
  input  logic              capture_en,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_data,
  output logic              frame_done,
  output logic              busy,
  output logic              sync_err
);

  typedef enum logic [1:0] {StIdle, StWaitVs, StFrame, StDone} state_e;

  localparam logic [9:0] PosMax = 10'h3ff;
  localparam logic [9:0] XLo    = 10'(HBP);
  localparam logic [9:0] XHi    = 10'(HBP + WIDTH);
  localparam logic [9:0] YLo    = 10'(VBP);
  localparam logic [9:0] YHi    = 10'(VBP + HEIGHT);
  localparam logic [9:0] XLast  = 10'(HBP + WIDTH - 1);
  localparam logic [9:0] YLast  = 10'(VBP + HEIGHT - 1);
  localparam logic [9:0] XEnd   = 10'(HTOTAL - 1);

  state_e state_q, state_d;

  logic       s1_hs, s1_vs, s2_hs, s2_vs;
  logic [2:0] s1_r, s1_g, s1_b;
  logic       hs_fall, vs_fall;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       vs_pend_q, vs_pend_d;   // VS fell, y resets on the next HS fall
  logic       first_hs_q, first_hs_d; // next HS fall is exempt from the length check
  logic       sync_err_d;
  logic       in_win, last_pix, we_d, bit_d;
  logic [4:0] sum;
  logic [ADDR_W-1:0] addr_d;

  assign hs_fall = ~s1_hs & s2_hs;
  assign vs_fall = ~s1_vs & s2_vs;
  assign busy    = (state_q == StWaitVs) || (state_q == StFrame);

  // Position of the pixel currently in s1.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    vs_pend_d = vs_pend_q;
    if (hs_fall) begin
      x_d = '0;
      if (vs_fall || vs_pend_q) begin
        y_d = '0;
      end else if (y_q != PosMax) begin
        y_d = y_q + 10'd1;
      end
      vs_pend_d = 1'b0;
    end else begin
      if (x_q != PosMax) x_d = x_q + 10'd1;
      if (vs_fall) vs_pend_d = 1'b1;
    end
  end

  always_comb begin
    in_win   = (x_d >= XLo) && (x_d < XHi) && (y_d >= YLo) && (y_d < YHi);
    last_pix = (x_d == XLast) && (y_d == YLast);
    addr_d   = ADDR_W'(y_d - YLo) * ADDR_W'(WIDTH) + ADDR_W'(x_d - XLo);
    sum      = {2'b00, s1_r} + {2'b00, s1_g} + {2'b00, s1_b};
    bit_d    = (sum >= 5'(THRESH));
  end

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    sync_err_d = sync_err;
    first_hs_d = first_hs_q;
    unique case (state_q)
      StIdle: begin
        if (capture_en) begin
          state_d    = StWaitVs;
          sync_err_d = 1'b0;
          first_hs_d = 1'b1;
        end
      end
      StWaitVs: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d = StFrame;
        end
      end
      StFrame: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else if (in_win) begin
          we_d = 1'b1;
          if (last_pix) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (busy && hs_fall) begin
      if (!first_hs_q && (x_q != XEnd)) sync_err_d = 1'b1;
      first_hs_d = 1'b0;
    end
    // A new VS inside a frame means the source restarted; y resets via vs_pend.
    if ((state_q == StFrame) && vs_fall) sync_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CPU_RESETN) begin
      state_q    <= StIdle;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s2_hs      <= 1'b1;
      s2_vs      <= 1'b1;
      s1_r       <= '0;
      s1_g       <= '0;
      s1_b       <= '0;
      x_q        <= PosMax;
      y_q        <= PosMax;
      vs_pend_q  <= 1'b0;
      first_hs_q <= 1'b0;
      sync_err   <= 1'b0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_hs      <= VGA_HS;
      s1_vs      <= VGA_VS;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s1_r       <= VGA_R;
      s1_g       <= VGA_G;
      s1_b       <= VGA_B;
      x_q        <= x_d;
      y_q        <= y_d;
      vs_pend_q  <= vs_pend_d;
      first_hs_q <= first_hs_d;
      sync_err   <= sync_err_d;
      pix_we     <= we_d;
      if (we_d) begin
        pix_addr <= addr_d;
        pix_data <= bit_d;
      end
      frame_done <= (state_q == StDone);
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture. Horizontal/vertical timing is scaled down
// (40-clock lines, 14-line frames) so several whole frames fit in a short run;
// the 9x9 capture window and threshold keep their default values.
`timescale 1ns/1ps
module tb_vga_capture;
  localparam int W    = 9;
  localparam int H    = 9;
  localparam int HBP  = 16;
  localparam int VBP  = 3;
  localparam int HTOT = 40;
  localparam int THR  = 11;
  localparam int AW   = 7;
  localparam int HSW  = 4;
  localparam int VT   = 14;

  logic          CLK = 1'b0;
  logic          CPU_RESETN;
  logic          VGA_HS, VGA_VS;
  logic [2:0]    VGA_R, VGA_G, VGA_B;
  logic          capture_en;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic          pix_data, frame_done, busy, sync_err;

  always #20 CLK = ~CLK;

  vga_capture #(
    .WIDTH(W), .HEIGHT(H), .HBP(HBP), .VBP(VBP), .HTOTAL(HTOT), .THRESH(THR), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .capture_en(capture_en),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_done(frame_done), .busy(busy), .sync_err(sync_err)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Write / pulse log.
  int wr_addr [512];
  bit wr_data [512];
  int wr_cyc  [512];
  int wr_n = 0;
  int fd_n = 0;
  int fd_cyc = 0;
  bit fd_serr = 1'b0;
  int busy_fall = -1;
  bit busy_prev = 1'b0;

  always @(negedge CLK) begin
    if (pix_we === 1'b1) begin
      if (wr_n < 512) begin
        wr_addr[wr_n] = int'(pix_addr);
        wr_data[wr_n] = pix_data;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (frame_done === 1'b1) begin
      fd_n    = fd_n + 1;
      fd_cyc  = cyc;
      fd_serr = sync_err;
    end
    if (busy_prev && (busy === 1'b0)) busy_fall = cyc;
    busy_prev = (busy === 1'b1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int pin_cyc [W*H];
  int drop_cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pix_rgb(input int mode, input int row, input int col);
    if (mode == 0) return 9'h1ff;
    if (row == 0 && col == 0) return {3'd4, 3'd3, 3'd3};  // sum 10
    if (row == 0 && col == 1) return {3'd4, 3'd4, 3'd3};  // sum 11
    return (((row + col) % 2) == 0) ? 9'h1ff : 9'h000;
  endfunction

  function automatic int exp_bit(input int mode, input int addr);
    logic [8:0] p;
    int s;
    p = pix_rgb(mode, addr / W, addr % W);
    s = int'(p[8:6]) + int'(p[5:3]) + int'(p[2:0]);
    return (s >= THR) ? 1 : 0;
  endfunction

  // One line; lidx is the line index counted from the VS-fall line.
  task automatic drive_line(input int lidx, input bit vs_low, input int len, input int mode,
                            input int drop_off);
    logic [8:0] p;
    int row, col;
    for (int k = 0; k < len; k++) begin
      @(posedge CLK);
      #1;
      VGA_HS = (k < HSW) ? 1'b0 : 1'b1;
      VGA_VS = ~vs_low;
      row = lidx - VBP;
      col = k - HBP;
      if (row >= 0 && row < H && col >= 0 && col < W) begin
        p = pix_rgb(mode, row, col);
        pin_cyc[row*W+col] = cyc;
      end else begin
        p = '0;
      end
      {VGA_R, VGA_G, VGA_B} = p;
      if (k == drop_off) begin
        capture_en = 1'b0;
        drop_cyc   = cyc;
      end
    end
  endtask

  task automatic drive_frame(input int mode, input int nlines, input int drop_line,
                             input int drop_off);
    for (int l = 0; l < nlines; l++)
      drive_line(l, (l < 2), HTOT, mode, (l == drop_line) ? drop_off : -1);
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic check_frame(input int base, input int mode);
    for (int i = 0; i < W*H; i++) begin
      chk($sformatf("addr[%0d]", i), wr_addr[base+i], i);
      chk($sformatf("data[%0d]", i), int'(wr_data[base+i]), exp_bit(mode, i));
      chk($sformatf("latency[%0d]", i), wr_cyc[base+i], pin_cyc[i] + 2);
    end
  endtask

  task automatic check_zero_outputs(input string pre);
    chk({pre, "_pix_we"}, int'(pix_we), 0);
    chk({pre, "_pix_addr"}, int'(pix_addr), 0);
    chk({pre, "_pix_data"}, int'(pix_data), 0);
    chk({pre, "_frame_done"}, int'(frame_done), 0);
    chk({pre, "_busy"}, int'(busy), 0);
    chk({pre, "_sync_err"}, int'(sync_err), 0);
  endtask

  int base, fd0, wr0;

  initial begin
    CPU_RESETN = 1'b1;
    VGA_HS = 1'b1;
    VGA_VS = 1'b1;
    {VGA_R, VGA_G, VGA_B} = '0;
    capture_en = 1'b0;
    repeat (3) @(posedge CLK);
    settle();
    check_zero_outputs("por");
    @(posedge CLK); #1 CPU_RESETN = 1'b0;
    repeat (4) @(posedge CLK);
    #1 capture_en = 1'b1;
    drive_line(-100, 1'b0, HTOT, 0, -1);
    settle();
    chk("busy_wait_vs", int'(busy), 1);

    // All-white frame.
    base = wr_n; fd0 = fd_n;
    drive_frame(0, VT, -1, -1);
    settle();
    chk("white_count", wr_n - base, 81);
    check_frame(base, 0);
    chk("white_fd_count", fd_n - fd0, 1);
    chk("white_fd_cycle", fd_cyc, wr_cyc[base+80] + 1);
    chk("white_serr", int'(fd_serr), 0);

    // Checkerboard with threshold-boundary pixels, captured back to back.
    base = wr_n; fd0 = fd_n;
    drive_frame(1, VT, -1, -1);
    settle();
    chk("cb_count", wr_n - base, 81);
    check_frame(base, 1);
    chk("sum10_bit", int'(wr_data[base]), 0);
    chk("sum11_bit", int'(wr_data[base+1]), 1);
    chk("cb_fd_count", fd_n - fd0, 1);
    chk("cb_serr", int'(fd_serr), 0);

    // capture_en drops with row 4 col 3 on the pins: writes through row 4 col 1 only.
    base = wr_n; fd0 = fd_n;
    drive_frame(0, VT, VBP + 4, HBP + 3);
    settle();
    chk("drop_count", wr_n - base, 38);
    chk("drop_last_addr", wr_addr[base+37], 37);
    chk("drop_last_cycle", wr_cyc[base+37], drop_cyc);
    chk("drop_busy_fall", busy_fall, drop_cyc + 1);
    chk("drop_fd_count", fd_n - fd0, 0);
    chk("drop_busy", int'(busy), 0);

    // Short line.
    @(posedge CLK); #1 capture_en = 1'b1;
    drive_line(-100, 1'b0, HTOT, 0, -1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    settle();
    chk("serr_good_lines", int'(sync_err), 0);
    drive_line(-100, 1'b0, HTOT - 1, 0, -1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    settle();
    chk("serr_short_line", int'(sync_err), 1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    settle();
    chk("serr_sticky", int'(sync_err), 1);
    @(posedge CLK); #1 capture_en = 1'b0;
    repeat (3) settle();
    chk("serr_sticky_idle", int'(sync_err), 1);
    @(posedge CLK); #1 capture_en = 1'b1;
    settle();
    settle();
    chk("serr_cleared", int'(sync_err), 0);

    // VS fall after row 2, then a complete frame.
    drive_line(-100, 1'b0, HTOT, 0, -1);
    base = wr_n; fd0 = fd_n;
    drive_frame(0, 6, -1, -1);
    drive_frame(0, VT, -1, -1);
    settle();
    chk("vsi_count", wr_n - base, 108);
    chk("vsi_pre_addr", wr_addr[base+26], 26);
    check_frame(base + 27, 0);
    chk("vsi_fd_count", fd_n - fd0, 1);
    chk("vsi_fd_cycle", fd_cyc, wr_cyc[base+107] + 1);
    chk("vsi_serr", int'(fd_serr), 1);

    // Reset in the middle of row 3, with a write in flight.
    drive_frame(0, 6, -1, -1);
    drive_line(6, 1'b0, HBP + 4, 0, -1);
    fd0 = fd_n;
    @(posedge CLK); #1 CPU_RESETN = 1'b1;
    @(posedge CLK);
    settle();
    check_zero_outputs("rst");
    @(posedge CLK); #1 CPU_RESETN = 1'b0;
    wr0 = wr_n;
    drive_line(-100, 1'b0, HTOT, 0, -1);
    drive_line(-100, 1'b0, HTOT, 0, -1);
    settle();
    chk("rst_no_writes", wr_n - wr0, 0);
    chk("rst_no_fd", fd_n - fd0, 0);
    capture_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing/bitmap output block.
- Samples VGA_HS, VGA_VS and 3-bit RGB on the pixel clock and recovers pixel position from the sync edges.
- Thresholds each active pixel to 1 bit and writes the result into a WIDTH x HEIGHT bitmap store through a simple write port.
- Used for loopback checking of the display path and as a frame source for the edge detector.

Parameters:
- WIDTH, 9, captured pixels per line.
- HEIGHT, 9, captured lines per frame.
- HBP, 144, horizontal position of the first captured pixel, counted from the HS falling edge.
- VBP, 31, vertical line index of the first captured line, counted from the VS falling edge.
- HTOTAL, 800, expected clocks between consecutive HS falling edges.
- THRESH, 11, minimum R+G+B sum (range 0..21) that yields pix_data=1.
- ADDR_W, 7, width of pix_addr; must be at least ceil(log2(WIDTH*HEIGHT)).

Ports:
- CLK  in  1  pixel clock, 25 MHz.
- CPU_RESETN  in  1  reset: synchronous, active-high; the clock is CLK.
- VGA_HS  in  1  horizontal sync, active low.
- VGA_VS  in  1  vertical sync, active low.
- VGA_R  in  3  red.
- VGA_G  in  3  green.
- VGA_B  in  3  blue.
- capture_en  in  1  level; 1 = capture frames continuously.
- pix_we  out  1  bitmap write strobe.
- pix_addr  out  ADDR_W  row*WIDTH+col.
- pix_data  out  1  thresholded pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- busy  out  1  1 when state is WAIT_VS or FRAME.
- sync_err  out  1  sticky line-length or frame-restart error.

Behaviour:
- Reset (CPU_RESETN=1 at a CLK edge):
  - State goes to IDLE.
  - All outputs go to 0: pix_we, pix_addr, pix_data, frame_done, busy, sync_err.
  - The input sampling registers are cleared to HS=1, VS=1, RGB=0.
  - Reset asserted mid-frame aborts the frame with no frame_done pulse.
- Input sampling:
  - Inputs pass through one register stage (s1), then a second stage (s2) used for edge detection.
  - An HS fall is a cycle where s1.HS=0 and s2.HS=1. A VS fall is defined the same way on VS.
- Horizontal position:
  - x = 0 in the cycle an HS fall is detected.
  - x increments by 1 each following cycle and saturates at 1023.
- Vertical position:
  - y = 0 on the HS fall that coincides with a VS fall, or on the first HS fall after a VS fall.
  - y increments on each later HS fall.
- Active pixel: HBP <= x < HBP+WIDTH and VBP <= y < VBP+HEIGHT, with col = x-HBP and row = y-VBP.
- Write latency: a pixel present on the pins at cycle t produces pix_we=1 at cycle t+2, with registered pix_addr = row*WIDTH+col.
- pix_data = 1 when the zero-extended 5-bit sum R+G+B >= THRESH.
- pix_we is 0 outside the active window and in every state other than FRAME.
- State machine:
  - IDLE: go to WAIT_VS when capture_en=1. sync_err clears on this transition.
  - WAIT_VS: go to FRAME on a VS fall.
  - FRAME: go to DONE in the cycle the write with row=HEIGHT-1, col=WIDTH-1 is issued.
  - DONE: frame_done=1 for exactly one cycle, then go to IDLE.
  - Net effect: with capture_en held at 1, IDLE re-enters WAIT_VS immediately, so the next frame is captured without software action.
- capture_en=0 while in WAIT_VS or FRAME: go to IDLE the next cycle, with no further writes and no frame_done.
- VS fall while in FRAME before the last pixel: set sync_err, restart the frame (y=0), and stay in FRAME.
- HS fall while in WAIT_VS or FRAME with x != HTOTAL-1 in the preceding cycle: set sync_err. The first HS fall after entering WAIT_VS is exempt.
- sync_err holds until reset or the next IDLE->WAIT_VS transition.
- pix_addr holds its last value when pix_we=0.
- There is no back-pressure: the store must accept one write per cycle.

Test Plan:
- Reset check: assert CPU_RESETN for 2 cycles mid-FRAME -> all outputs 0 the next cycle, state IDLE, no frame_done pulse.
- Standard 800x521 timing with an all-white active region (R=G=B=7) and capture_en=1:
  - Expect exactly 81 writes with pix_data=1 and addresses 0..80 in order.
  - Expect frame_done one cycle after the address-80 write and sync_err=0.
- Checkerboard of R=G=B=7 and 0, plus a pixel with sum 10 versus sum 11:
  - pix_data matches the pattern.
  - The sum-10 pixel writes 0 and the sum-11 pixel writes 1.
  - Each pix_we appears exactly 2 cycles after the pixel is on the pins.
- Drop capture_en while writing row 4 -> pix_we=0 from the next cycle, no frame_done, busy=0.
- Shorten one line to 799 clocks -> sync_err=1 and sticky; it clears on the next capture_en 0->1 restart.
- Inject a VS fall after row 2 -> sync_err=1; writes restart at address 0 on the new frame and complete with frame_done.
